rf_wb_arbiter: RTL and testbench
================================

# rf_wb_arbiter

Sequential write-port arbiter for the 32-entry register file. It shares the single write port between the main pipeline writeback (port A) and a long-latency unit (port B, e.g. multiply/divide or load return), and drives the write-select decoder and register-file data input. Port A wins by default; a starvation counter forces a port B grant by stalling the pipeline after a bounded wait. Register 0 is write-protected here, so the decoder never receives an enable for it.

## Interface
- `MAX_WAIT`, default 4: consecutive cycles port B may lose before a forced grant; legal range 1..15.
- `DATA_W`, default 32: write data width.
- `SEL_W`, default 5: register select width.

- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `a_valid`  in  1  pipeline writeback request; no ready, single-cycle.
- `a_sel`  in  SEL_W  destination register for A.
- `a_data`  in  DATA_W  write data for A.
- `b_valid`  in  1  long-latency unit request.
- `b_ready`  out  1  B accepted this cycle (combinational).
- `b_sel`  in  SEL_W  destination register for B.
- `b_data`  in  DATA_W  write data for B.
- `stall_a`  out  1  pipeline must hold its writeback this cycle (registered).
- `rf_we`  out  1  write enable to decoder `eno` (registered).
- `rf_wsel`  out  SEL_W  write select to decoder `wsel` (registered).
- `rf_wdata`  out  DATA_W  register-file write data (registered).

## Operation
- States: IDLE (no B waiting), WAIT (B valid, lost ≥1 cycle), FORCE (B granted unconditionally).
- `b_ready` = (state==FORCE) | !a_valid. B transfer = `b_valid & b_ready`.
- Grant: FORCE -> B; else a_valid -> A; else B if b_valid; else none.
- In FORCE, `stall_a`=1; any `a_valid` that cycle is ignored, and the pipeline must re-present it.
- Wait counter (4 bits): cleared on B transfer and in IDLE; increments each cycle `b_valid & !b_ready`.
- IDLE -> WAIT on `b_valid & !b_ready`; IDLE stays on B transfer or no request.
- WAIT -> FORCE when a loss occurs with counter == MAX_WAIT-1; WAIT -> IDLE on B transfer; WAIT -> IDLE if `b_valid` drops (protocol violation, tolerated).
- FORCE -> IDLE always after one cycle.
- B protocol: once asserted, `b_valid`, `b_sel` and `b_data` hold stable until transfer.
- Register 0: a granted write with sel==0 is consumed (B handshakes normally) but yields `rf_we`=0.
- Next rf outputs: granted & sel!=0 -> we=1, wsel/wdata of winner; otherwise we=0 and wsel/wdata hold previous values.

## Timing
- Reset values: `rf_we`=0, `rf_wsel`=0, `rf_wdata`=0, `stall_a`=0, state IDLE, counter 0. `b_ready` follows its equation after reset.
- Latency: grant in cycle t -> `rf_*` valid in t+1 -> register file captures at end of t+1.
- `stall_a` is high during exactly the FORCE cycle. It is registered from the WAIT->FORCE decision, so the pipeline sees it in the same cycle the grant goes to B.
- Worst-case B wait: MAX_WAIT losing cycles, then 1 FORCE cycle.
- Simultaneous A and B with counter < MAX_WAIT-1: A written, B waits.
- Reset mid-WAIT/FORCE: pending B is dropped from arbiter state, and B re-presents after reset. Writes in flight to `rf_*` are cleared.

## Structure
- Shared package: state encoding constants (IDLE/WAIT/FORCE), `SEL_W`/`DATA_W` defaults, and the zero-register index constant.
- One sub-module is natural: `rf_wb_wait_ctr`, the saturating wait counter with clear/increment and a terminal flag. The FSM and output registers stay in the top level.

## Test plan
- Reset: hold `rst_n`=0 with random inputs -> `rf_we`=0, `rf_wsel`=0, `rf_wdata`=0, `stall_a`=0. Release, A writes sel=3 data=0xDEADBEEF -> next cycle `rf_we`=1, `rf_wsel`=3, `rf_wdata`=0xDEADBEEF.
- Idle B: `a_valid`=0, B sel=7 data=0x12 -> `b_ready`=1 same cycle; next cycle `rf_we`=1, `rf_wsel`=7.
- Starvation (MAX_WAIT=4): A valid every cycle, B valid from cycle 0 -> `b_ready`=0 for cycles 0-3. Cycle 4: `stall_a`=1, `b_ready`=1, A ignored. Cycle 5: B's write on `rf_*`, `stall_a`=0, A wins again.
- Register 0: A sel=0, then B sel=0 with a_valid=0 -> `rf_we` stays 0 both cycles, and B handshake completes.
- Back-to-back B: two B transfers with a_valid=0 -> two consecutive `rf_we`=1 cycles with correct sel/data, and the counter stays 0.
- Reset in WAIT: counter at 2, assert `rst_n`=0 -> state IDLE, counter 0. After release, B needs the full MAX_WAIT losses again before FORCE.

Source files
------------

// File: rtl/rf_wb_arbiter_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
package rf_wb_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StWait  = 2'd1,
    StForce = 2'd2
  } arb_state_e;

  localparam int unsigned DefSelW  = 5;
  localparam int unsigned DefDataW = 32;
  localparam int unsigned CtrW     = 4;
  localparam int unsigned ZeroReg  = 0;

endpackage

// File: rtl/rf_wb_wait_ctr.sv
// Saturating count of consecutive cycles port B has lost arbitration.
module rf_wb_wait_ctr
  import rf_wb_arbiter_pkg::*;
#(
  parameter int unsigned MaxWait = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic term
);

  logic [CtrW-1:0] cnt_q, cnt_d;

  // A clear that coincides with a loss restarts the count at one.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = {{(CtrW-1){1'b0}}, inc};
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign term = (cnt_q == CtrW'(MaxWait - 1));

endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the register-file write port between pipeline writeback (A) and a
// long-latency unit (B), forcing a B grant after a bounded wait.
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 4,
  parameter int unsigned DATA_W   = DefDataW,
  parameter int unsigned SEL_W    = DefSelW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_valid,
  input  logic [SEL_W-1:0]  a_sel,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [SEL_W-1:0]  b_sel,
  input  logic [DATA_W-1:0] b_data,
  output logic              stall_a,
  output logic              rf_we,
  output logic [SEL_W-1:0]  rf_wsel,
  output logic [DATA_W-1:0] rf_wdata
);

  arb_state_e state_q, state_d;

  logic              b_xfer, b_loss, grant_a, ctr_clr, ctr_term;
  logic [SEL_W-1:0]  win_sel;
  logic [DATA_W-1:0] win_data;
  logic              rf_we_d;
  logic [SEL_W-1:0]  rf_wsel_d;
  logic [DATA_W-1:0] rf_wdata_d;

  assign b_ready = (state_q == StForce) | ~a_valid;
  assign b_xfer  = b_valid & b_ready;
  assign b_loss  = b_valid & ~b_ready;
  assign grant_a = (state_q != StForce) & a_valid;
  assign ctr_clr = b_xfer | (state_q != StWait);

  rf_wb_wait_ctr #(
    .MaxWait (MAX_WAIT)
  ) u_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (ctr_clr),
    .inc   (b_loss),
    .term  (ctr_term)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        // The loss seen in IDLE is already the first one.
        if (b_loss) state_d = (MAX_WAIT == 1) ? StForce : StWait;
      end
      StWait: begin
        if (b_xfer || !b_valid) begin
          state_d = StIdle;
        end else if (b_loss && ctr_term) begin
          state_d = StForce;
        end
      end
      StForce: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    win_sel    = grant_a ? a_sel  : b_sel;
    win_data   = grant_a ? a_data : b_data;
    rf_we_d    = (grant_a | b_xfer) & (win_sel != SEL_W'(ZeroReg));
    rf_wsel_d  = rf_we_d ? win_sel  : rf_wsel;
    rf_wdata_d = rf_we_d ? win_data : rf_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      stall_a  <= 1'b0;
      rf_we    <= 1'b0;
      rf_wsel  <= '0;
      rf_wdata <= '0;
    end else begin
      state_q  <= state_d;
      stall_a  <= (state_d == StForce);
      rf_we    <= rf_we_d;
      rf_wsel  <= rf_wsel_d;
      rf_wdata <= rf_wdata_d;
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter with MAX_WAIT=4.
module tb_rf_wb_arbiter;
  import rf_wb_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_valid, b_valid, b_ready, stall_a, rf_we;
  logic [4:0]  a_sel, b_sel, rf_wsel;
  logic [31:0] a_data, b_data, rf_wdata;

  int n_checks = 0;
  int n_fail   = 0;

  rf_wb_arbiter #(
    .MAX_WAIT (4),
    .DATA_W   (32),
    .SEL_W    (5)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a_valid  (a_valid),
    .a_sel    (a_sel),
    .a_data   (a_data),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .b_sel    (b_sel),
    .b_data   (b_data),
    .stall_a  (stall_a),
    .rf_we    (rf_we),
    .rf_wsel  (rf_wsel),
    .rf_wdata (rf_wdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    // Reset with random inputs
    for (int i = 0; i < 3; i++) begin
      a_valid = 1'($urandom); a_sel = 5'($urandom); a_data = $urandom;
      b_valid = 1'($urandom); b_sel = 5'($urandom); b_data = $urandom;
      tick();
      chk("rst_we", rf_we, 0);
      chk("rst_wsel", rf_wsel, 0);
      chk("rst_wdata", rf_wdata, 0);
      chk("rst_stall", stall_a, 0);
    end

    rst_n = 1'b1;
    a_valid = 1; a_sel = 3; a_data = 32'hDEADBEEF; b_valid = 0;
    tick();
    chk("a_we", rf_we, 1);
    chk("a_wsel", rf_wsel, 3);
    chk("a_wdata", rf_wdata, 32'hDEADBEEF);

    // Idle B
    a_valid = 0; b_valid = 1; b_sel = 7; b_data = 32'h12;
    #1 chk("idleb_ready", b_ready, 1);
    tick();
    b_valid = 0;
    chk("idleb_we", rf_we, 1);
    chk("idleb_wsel", rf_wsel, 7);
    chk("idleb_wdata", rf_wdata, 32'h12);

    // Starvation: A every cycle, B held from cycle 0
    a_valid = 1; a_sel = 5; b_valid = 1; b_sel = 9; b_data = 32'hBB;
    for (int c = 0; c < 4; c++) begin
      a_data = 32'h100 + c;
      #1;
      chk("starve_ready", b_ready, 0);
      chk("starve_stall", stall_a, 0);
      tick();
      chk("starve_a_we", rf_we, 1);
      chk("starve_a_wsel", rf_wsel, 5);
      chk("starve_a_wdata", rf_wdata, 32'h100 + c);
    end
    a_data = 32'h104;
    #1;
    chk("force_stall", stall_a, 1);
    chk("force_ready", b_ready, 1);
    tick();
    chk("force_b_we", rf_we, 1);
    chk("force_b_wsel", rf_wsel, 9);
    chk("force_b_wdata", rf_wdata, 32'hBB);
    chk("post_force_stall", stall_a, 0);
    b_valid = 0; a_data = 32'h105;
    #1 chk("post_force_ready", b_ready, 0);
    tick();
    chk("post_force_a_wdata", rf_wdata, 32'h105);

    // Register 0 is never written
    a_sel = 0; a_data = 32'h55;
    tick();
    chk("r0_a_we", rf_we, 0);
    chk("r0_a_hold", rf_wdata, 32'h105);
    a_valid = 0; b_valid = 1; b_sel = 0; b_data = 32'h66;
    #1 chk("r0_b_ready", b_ready, 1);
    tick();
    b_valid = 0;
    chk("r0_b_we", rf_we, 0);
    chk("r0_b_hold", rf_wsel, 5);

    // Back-to-back B
    b_valid = 1; b_sel = 10; b_data = 32'hA;
    #1 chk("b2b_ready0", b_ready, 1);
    tick();
    b_sel = 11; b_data = 32'hB;
    #1 chk("b2b_ready1", b_ready, 1);
    chk("b2b_we0", rf_we, 1);
    chk("b2b_wsel0", rf_wsel, 10);
    chk("b2b_wdata0", rf_wdata, 32'hA);
    tick();
    b_valid = 0;
    chk("b2b_we1", rf_we, 1);
    chk("b2b_wsel1", rf_wsel, 11);
    chk("b2b_wdata1", rf_wdata, 32'hB);
    chk("b2b_cnt", 32'(dut.u_ctr.cnt_q), 0);
    tick();
    chk("idle_we", rf_we, 0);
    chk("idle_hold", rf_wsel, 11);

    // Reset while in WAIT with counter at 2
    a_valid = 1; a_sel = 4; a_data = 32'h44; b_valid = 1; b_sel = 12; b_data = 32'hCC;
    tick();
    tick();
    chk("wait_cnt2", 32'(dut.u_ctr.cnt_q), 2);
    chk("wait_state", 32'(dut.state_q), 32'(StWait));
    rst_n = 0;
    #1;
    chk("rstw_cnt", 32'(dut.u_ctr.cnt_q), 0);
    chk("rstw_state", 32'(dut.state_q), 32'(StIdle));
    chk("rstw_we", rf_we, 0);
    chk("rstw_wdata", rf_wdata, 0);
    tick();
    rst_n = 1;
    for (int c = 0; c < 4; c++) begin
      #1 chk("rstw_loss_ready", b_ready, 0);
      tick();
    end
    #1;
    chk("rstw_force_stall", stall_a, 1);
    chk("rstw_force_ready", b_ready, 1);
    tick();
    b_valid = 0; a_valid = 0;
    chk("rstw_b_wsel", rf_wsel, 12);
    chk("rstw_b_wdata", rf_wdata, 32'hCC);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
